// File: rtl/butterfly_pkg.sv
// Shared types and constants for the butterfly operand/result sequencer.
// The slot-to-byte mapping helper lives here so that every user orders the slots the same way.
package butterfly_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    GAP,
    DONE
  } state_t;

  localparam int NUM_TX    = 6;
  localparam int NUM_RX    = 4;
  localparam int NUM_SLOTS = NUM_TX + NUM_RX;
  localparam int TIMER_W   = 16;

  typedef logic [3:0]              slot_t;
  typedef logic signed [7:0]       sbyte_t;
  typedef logic [NUM_TX-1:0][7:0]  opvec_t;

  // Index 0 is Rew and index 5 is Ima. Receive slots present zero on Sw.
  function automatic sbyte_t txByte(input opvec_t ops, input slot_t slot);
    case (slot)
      4'd0:    txByte = sbyte_t'(ops[0]);
      4'd1:    txByte = sbyte_t'(ops[1]);
      4'd2:    txByte = sbyte_t'(ops[2]);
      4'd3:    txByte = sbyte_t'(ops[3]);
      4'd4:    txByte = sbyte_t'(ops[4]);
      4'd5:    txByte = sbyte_t'(ops[5]);
      default: txByte = '0;
    endcase
  endfunction

endpackage

// File: rtl/butterfly_driver_timer.sv
// Loadable down-counter with a terminal-count flag.
// The top loads it with (phase length - 1) on entry to each SETUP, PULSE and GAP phase.
module bfly_slot_timer #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] loadVal_i,
  output logic         tc_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = loadVal_i;
    end else if (count_q != '0) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == '0);

endmodule

// File: rtl/butterfly_driver.sv
// Serialises one butterfly operand set onto Sw/ReadyIn, then clocks the four result bytes back off Led.
// All outputs are registered, so ReadyIn and Sw are glitch-free at the pins.
module butterfly_driver
  import butterfly_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int HOLD_CYCLES   = 50,
  parameter int GAP_CYCLES    = 50
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [7:0] opRew_i,
  input  logic [7:0] opImw_i,
  input  logic [7:0] opReb_i,
  input  logic [7:0] opImb_i,
  input  logic [7:0] opRea_i,
  input  logic [7:0] opIma_i,
  output logic [7:0] sw_o,
  output logic       readyIn_o,
  input  logic [7:0] led_i,
  output logic [7:0] resRey_o,
  output logic [7:0] resImy_o,
  output logic [7:0] resRez_o,
  output logic [7:0] resImz_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam logic [TIMER_W-1:0] SETTLE_LOAD = TIMER_W'(SETTLE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] HOLD_LOAD   = TIMER_W'(HOLD_CYCLES - 1);
  localparam logic [TIMER_W-1:0] GAP_LOAD    = TIMER_W'(GAP_CYCLES - 1);
  localparam slot_t FIRST_RX  = slot_t'(NUM_TX);
  localparam slot_t LAST_SLOT = slot_t'(NUM_SLOTS - 1);

  state_t             state_q, state_d;
  slot_t              slot_q, slot_d;
  logic [7:0]         sw_q, sw_d;
  opvec_t             ops_q;
  sbyte_t             resRey_q, resImy_q, resRez_q, resImz_q;
  logic               readyIn_q, busy_q, done_q;
  logic               latchOps, capture, timerLoad, timerTc;
  logic [TIMER_W-1:0] timerLoadVal;

  bfly_slot_timer #(
    .W(TIMER_W)
  ) u_timer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load_i   (timerLoad),
    .loadVal_i(timerLoadVal),
    .tc_o     (timerTc)
  );

  // DONE also accepts Start so back-to-back requests lose no cycle.
  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    sw_d         = sw_q;
    latchOps     = 1'b0;
    capture      = 1'b0;
    timerLoad    = 1'b0;
    timerLoadVal = '0;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start_i) begin
          state_d      = SETUP;
          slot_d       = '0;
          sw_d         = opRew_i;
          latchOps     = 1'b1;
          timerLoad    = 1'b1;
          timerLoadVal = SETTLE_LOAD;
        end
      end
      SETUP: begin
        if (timerTc) begin
          state_d      = PULSE;
          timerLoad    = 1'b1;
          timerLoadVal = HOLD_LOAD;
        end
      end
      PULSE: begin
        if (timerTc) begin
          state_d      = GAP;
          capture      = (slot_q >= FIRST_RX);
          timerLoad    = 1'b1;
          timerLoadVal = GAP_LOAD;
        end
      end
      GAP: begin
        if (timerTc) begin
          if (slot_q == LAST_SLOT) begin
            state_d = DONE;
            sw_d    = '0;
          end else begin
            state_d      = SETUP;
            slot_d       = slot_q + 4'd1;
            sw_d         = txByte(ops_q, slot_q + 4'd1);
            timerLoad    = 1'b1;
            timerLoadVal = SETTLE_LOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      slot_q    <= '0;
      sw_q      <= '0;
      ops_q     <= '0;
      readyIn_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      resRey_q  <= '0;
      resImy_q  <= '0;
      resRez_q  <= '0;
      resImz_q  <= '0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      sw_q      <= sw_d;
      readyIn_q <= (state_d == PULSE);
      busy_q    <= (state_d == SETUP) || (state_d == PULSE) || (state_d == GAP);
      done_q    <= (state_d == DONE);
      if (latchOps) begin
        ops_q <= {opIma_i, opRea_i, opImb_i, opReb_i, opImw_i, opRew_i};
      end
      // Led is taken on the last PULSE cycle of each receive slot.
      if (capture) begin
        case (slot_q)
          4'd6:    resRey_q <= sbyte_t'(led_i);
          4'd7:    resImy_q <= sbyte_t'(led_i);
          4'd8:    resRez_q <= sbyte_t'(led_i);
          4'd9:    resImz_q <= sbyte_t'(led_i);
          default: ;
        endcase
      end
    end
  end

  assign sw_o      = sw_q;
  assign readyIn_o = readyIn_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign resRey_o  = resRey_q;
  assign resImy_o  = resImy_q;
  assign resRez_o  = resRez_q;
  assign resImz_o  = resImz_q;

endmodule

// File: tb/tb_butterfly_driver.sv
// Bench for butterfly_driver: a short-timing instance and a default-timing instance,
// both checked cycle by cycle against the slot timing arithmetic.
module tb_butterfly_driver;

  localparam int SA = 1, HA = 3, GA = 2, LA = SA + HA + GA;
  localparam int SB = 2, HB = 50, GB = 50, LB = SB + HB + GB;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic       rstA, startA;
  logic [7:0] opA[6];
  logic [7:0] ledA;
  logic [7:0] swA, resReyA, resImyA, resRezA, resImzA;
  logic       readyA, busyA, doneA;

  logic       rstB, startB;
  logic [7:0] opB[6];
  logic [7:0] ledB;
  logic [7:0] swB, resReyB, resImyB, resRezB, resImzB;
  logic       readyB, busyB, doneB;

  logic [7:0] respA[4];
  logic [7:0] resExp[4];

  butterfly_driver #(
    .SETTLE_CYCLES(SA),
    .HOLD_CYCLES  (HA),
    .GAP_CYCLES   (GA)
  ) dutA (
    .clk_i(clk), .rst_i(rstA), .start_i(startA),
    .opRew_i(opA[0]), .opImw_i(opA[1]), .opReb_i(opA[2]),
    .opImb_i(opA[3]), .opRea_i(opA[4]), .opIma_i(opA[5]),
    .sw_o(swA), .readyIn_o(readyA), .led_i(ledA),
    .resRey_o(resReyA), .resImy_o(resImyA), .resRez_o(resRezA), .resImz_o(resImzA),
    .busy_o(busyA), .done_o(doneA)
  );

  butterfly_driver dutB (
    .clk_i(clk), .rst_i(rstB), .start_i(startB),
    .opRew_i(opB[0]), .opImw_i(opB[1]), .opReb_i(opB[2]),
    .opImb_i(opB[3]), .opRea_i(opB[4]), .opIma_i(opB[5]),
    .sw_o(swB), .readyIn_o(readyB), .led_i(ledB),
    .resRey_o(resReyB), .resImy_o(resImyB), .resRez_o(resRezB), .resImz_o(resImzB),
    .busy_o(busyB), .done_o(doneB)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Butterfly model: presents the correct result byte only on the last cycle of each
  // receive pulse and junk that matches no result byte everywhere else.
  int   pulseCnt = 0;
  int   pulseCyc = 0;
  logic prevReady = 1'b0;
  always @(negedge clk) begin
    logic [7:0] junk;
    if (!busyA) begin
      pulseCnt = 0;
      pulseCyc = 0;
    end else if (readyA && !prevReady) begin
      pulseCnt++;
      pulseCyc = 0;
    end else if (readyA) begin
      pulseCyc++;
    end
    junk = 8'($urandom);
    for (int i = 0; i < 5; i++)
      if (junk == respA[0] || junk == respA[1] || junk == respA[2] || junk == respA[3])
        junk = junk + 8'd1;
    if (busyA && readyA && pulseCnt >= 7 && pulseCnt <= 10 && pulseCyc == HA - 1)
      ledA = respA[pulseCnt-7];
    else
      ledA = junk;
    prevReady = readyA;
  end

  task automatic checkResA();
    checkOutput("resReyA", resReyA, resExp[0]);
    checkOutput("resImyA", resImyA, resExp[1]);
    checkOutput("resRezA", resRezA, resExp[2]);
    checkOutput("resImzA", resImzA, resExp[3]);
  endtask

  task automatic checkIdleA(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      checkOutput("idleBusyA", busyA, 0);
      checkOutput("idleReadyA", readyA, 0);
      checkOutput("idleDoneA", doneA, 0);
      checkResA();
    end
  endtask

  // startMode: 0 = single pulse, 1 = random re-assertion mid-transaction,
  // 2 = held high to the end for a back-to-back follow-up. abortAt < 0 means no reset.
  task automatic applyStimulus(input logic [5:0][7:0] ops, input logic [3:0][7:0] resp,
                               input int startMode, input bit changeOps, input int abortAt);
    int n, r;
    for (int i = 0; i < 6; i++) opA[i] = ops[i];
    for (int i = 0; i < 4; i++) respA[i] = resp[i];
    startA = 1'b1;
    for (int t = 0; t <= 10 * LA; t++) begin
      @(negedge clk);
      n = t / LA;
      r = t % LA;
      if (t < 10 * LA) begin
        if (n >= 6 && r == SA + HA) resExp[n-6] = resp[n-6];
        checkOutput("swA", swA, (n < 6) ? ops[n] : 8'h00);
        checkOutput("readyInA", readyA, (r >= SA && r < SA + HA) ? 1 : 0);
        checkOutput("busyA", busyA, 1);
        checkOutput("doneA", doneA, 0);
      end else begin
        checkOutput("doneA", doneA, 1);
        checkOutput("busyDoneA", busyA, 0);
        checkOutput("readyDoneA", readyA, 0);
      end
      checkResA();
      if (startMode == 0) startA = 1'b0;
      else if (startMode == 1) startA = (t < 10 * LA - 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (changeOps) for (int i = 0; i < 6; i++) opA[i] = 8'($urandom);
      if (t == abortAt) begin
        rstA   = 1'b1;
        startA = 1'b1;
        @(negedge clk);
        rstA   = 1'b0;
        startA = 1'b0;
        for (int i = 0; i < 4; i++) resExp[i] = 8'h00;
        checkOutput("rstReadyA", readyA, 0);
        checkOutput("rstSwA", swA, 0);
        checkOutput("rstBusyA", busyA, 0);
        checkOutput("rstDoneA", doneA, 0);
        checkResA();
        return;
      end
    end
  endtask

  function automatic logic [5:0][7:0] randOps();
    logic [5:0][7:0] v;
    for (int i = 0; i < 6; i++) v[i] = 8'($urandom);
    return v;
  endfunction

  function automatic logic [3:0][7:0] randResp();
    logic [3:0][7:0] v;
    for (int i = 0; i < 4; i++) v[i] = 8'($urandom);
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [5:0][7:0] opsB;
    int n, r;
    rstA = 1'b1; startA = 1'b0;
    rstB = 1'b1; startB = 1'b0;
    ledB = 8'h5A;
    for (int i = 0; i < 6; i++) begin opA[i] = 8'h00; opB[i] = 8'h00; end
    for (int i = 0; i < 4; i++) begin respA[i] = 8'h00; resExp[i] = 8'h00; end
    repeat (3) @(negedge clk);
    checkOutput("rstSw", swA, 0);
    checkOutput("rstReady", readyA, 0);
    checkOutput("rstBusy", busyA, 0);
    checkOutput("rstDone", doneA, 0);
    checkResA();
    rstA = 1'b0;
    rstB = 1'b0;
    checkIdleA(2);

    $display("[TB] nominal transaction");
    applyStimulus({8'h07, 8'h03, 8'h06, 8'h04, 8'hC0, 8'h60},
                  {8'h44, 8'h33, 8'h22, 8'h11}, 0, 1'b0, -1);
    checkIdleA(3);

    $display("[TB] restart attempts and operand changes mid-transaction");
    applyStimulus(randOps(), randResp(), 1, 1'b1, -1);
    checkIdleA(2);

    $display("[TB] reset during slot 3 pulse");
    applyStimulus(randOps(), randResp(), 0, 1'b0, 3 * LA + SA + 1);
    checkIdleA(2);
    applyStimulus(randOps(), randResp(), 0, 1'b0, -1);
    checkIdleA(2);

    $display("[TB] back-to-back transactions");
    applyStimulus(randOps(), randResp(), 2, 1'b0, -1);
    applyStimulus(randOps(), randResp(), 2, 1'b1, -1);
    applyStimulus(randOps(), randResp(), 0, 1'b0, -1);
    checkIdleA(2);

    $display("[TB] random transactions");
    for (int k = 0; k < 3; k++) begin
      applyStimulus(randOps(), randResp(), int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
      checkIdleA(int'($urandom_range(1, 4)));
    end

    $display("[TB] default timing instance");
    opsB = randOps();
    for (int i = 0; i < 6; i++) opB[i] = opsB[i];
    startB = 1'b1;
    for (int t = 0; t <= 10 * LB; t++) begin
      @(negedge clk);
      startB = 1'b0;
      n = t / LB;
      r = t % LB;
      if (t < 10 * LB) begin
        checkOutput("swB", swB, (n < 6) ? opsB[n] : 8'h00);
        checkOutput("readyInB", readyB, (r >= SB && r < SB + HB) ? 1 : 0);
        checkOutput("busyB", busyB, 1);
        checkOutput("doneB", doneB, 0);
      end else begin
        checkOutput("doneB", doneB, 1);
        checkOutput("busyDoneB", busyB, 0);
      end
    end
    @(negedge clk);
    checkOutput("doneAfterB", doneB, 0);
    checkOutput("resReyB", resReyB, 8'h5A);
    checkOutput("resImyB", resImyB, 8'h5A);
    checkOutput("resRezB", resRezB, 8'h5A);
    checkOutput("resImzB", resImzB, 8'h5A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
